// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding and counter widths.
package uart_tx_sched_pkg;

   localparam int CNT_W   = 16;
   localparam int FLUSH_W = 24;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RD      = 3'd1;
   localparam logic [2:0] LATCH   = 3'd2;
   localparam logic [2:0] SEND    = 3'd3;
   localparam logic [2:0] WAIT_HI = 3'd4;
   localparam logic [2:0] WAIT_LO = 3'd5;
   localparam logic [2:0] GAP     = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE    = IDLE,
      ST_RD      = RD,
      ST_LATCH   = LATCH,
      ST_SEND    = SEND,
      ST_WAIT_HI = WAIT_HI,
      ST_WAIT_LO = WAIT_LO,
      ST_GAP     = GAP
   } state_t;

   // Last count value of an N-cycle window; a zero-length window still lasts one cycle.
   function automatic logic [CNT_W-1:0] last_count(input int n);
      return (n <= 1) ? '0 : CNT_W'(n - 1);
   endfunction

endpackage

// File: rtl/uart_tx_flush_timer.sv
// Line-idle timer: counts cycles with buffered data and no new byte, flags when FLUSH_CYC is reached.
module uart_tx_flush_timer
   import uart_tx_sched_pkg::*;
#(
   parameter int FLUSH_CYC = 434000
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic rx_done,
   input  logic fifo_empty,
   input  logic clear,
   output logic flush_req
);

   logic [FLUSH_W-1:0] idle_cnt;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         idle_cnt <= '0;
      end else if (rx_done || fifo_empty || clear) begin
         idle_cnt <= '0;
      end else if (idle_cnt != '1) begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end

   assign flush_req = (idle_cnt == FLUSH_W'(FLUSH_CYC));

endmodule

// File: rtl/uart_tx_sched.sv
// Transmit scheduler between the RX byte FIFO and the UART transmitter.
// Optional line-idle flush is built when UART_TX_FLUSH_EN is defined.
module uart_tx_sched #(
   parameter int AW        = 8,
   parameter int THRESH    = 16,
   parameter int GAP_CYC   = 0,
   parameter int BUSY_TO   = 64,
   parameter int FLUSH_CYC = 434000
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic          rx_done,
   input  logic          fifo_empty,
   input  logic          fifo_full,
   input  logic [AW-1:0] fifo_usedw,
   input  logic [7:0]    fifo_q,
   output logic          fifo_rdreq,
   output logic          tx_en,
   output logic [7:0]    tx_data,
   input  logic          tx_busy,
   output logic          sched_active,
   output logic          tx_err
);

   import uart_tx_sched_pkg::*;

   localparam logic [CNT_W-1:0] GAP_LAST = last_count(GAP_CYC);
   localparam logic [CNT_W-1:0] TO_LAST  = last_count(BUSY_TO);

   state_t           state;
   logic             burst;
   logic [CNT_W-1:0] gap_cnt;
   logic [CNT_W-1:0] to_cnt;
   logic             flush_req;
   logic             trigger;
   logic             burst_start;

   assign trigger     = !fifo_empty &&
                        ((fifo_usedw >= AW'(THRESH)) || fifo_full || flush_req);
   assign burst_start = (state == ST_IDLE) && trigger;

`ifdef UART_TX_FLUSH_EN
   uart_tx_flush_timer #(
      .FLUSH_CYC (FLUSH_CYC)
   ) u_flush_timer (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .rx_done    (rx_done),
      .fifo_empty (fifo_empty),
      .clear      (burst_start),
      .flush_req  (flush_req)
   );
`else
   logic unused_flush;
   assign flush_req    = 1'b0;
   assign unused_flush = ^{rx_done, FLUSH_W'(FLUSH_CYC)};
`endif

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state        <= ST_IDLE;
         burst        <= 1'b0;
         gap_cnt      <= '0;
         to_cnt       <= '0;
         fifo_rdreq   <= 1'b0;
         tx_en        <= 1'b0;
         tx_data      <= '0;
         sched_active <= 1'b0;
         tx_err       <= 1'b0;
      end else begin
         // NOTE: strobes default low here, so every branch that raises one yields a single-cycle pulse.
         fifo_rdreq <= 1'b0;
         tx_en      <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (burst_start) begin
                  state        <= ST_RD;
                  fifo_rdreq   <= 1'b1;
                  burst        <= 1'b1;
                  sched_active <= 1'b1;
               end
            end
            ST_RD: begin
               state <= ST_LATCH;
            end
            ST_LATCH: begin
               tx_data <= fifo_q;
               tx_en   <= 1'b1;
               state   <= ST_SEND;
            end
            ST_SEND: begin
               // The tx_en cycle counts as the first cycle of the busy timeout window.
               to_cnt <= CNT_W'(1);
               state  <= ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
               if (tx_busy) begin
                  state <= ST_WAIT_LO;
               end else if (to_cnt >= TO_LAST) begin
                  tx_err  <= 1'b1;
                  gap_cnt <= '0;
                  state   <= ST_GAP;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            ST_WAIT_LO: begin
               if (!tx_busy) begin
                  gap_cnt <= '0;
                  state   <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (gap_cnt >= GAP_LAST) begin
                  if (!fifo_empty && (burst || trigger)) begin
                     state      <= ST_RD;
                     fifo_rdreq <= 1'b1;
                     burst      <= 1'b1;
                  end else begin
                     state        <= ST_IDLE;
                     burst        <= 1'b0;
                     sched_active <= 1'b0;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               state        <= ST_IDLE;
               burst        <= 1'b0;
               sched_active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler between the receive-side byte FIFO and the UART transmitter in the loopback path. It decides when buffered bytes are drained and pops them one at a time. It presents each byte to the transmitter and waits for that frame to finish before issuing the next pop. This replaces the "read when full" coupling, so partial buffers are drained on a level threshold and, optionally, on a line-idle timeout.

## Interface
Parameters:
- AW, 8: FIFO level width. fifo_usedw is AW bits.
- THRESH, 16: fifo_usedw level that starts a burst. Must satisfy 1 ≤ THRESH ≤ 2^AW−1.
- GAP_CYC, 0: idle cycles inserted between consecutive frames. 16-bit counter.
- BUSY_TO, 64: cycles allowed for tx_busy to rise after tx_en. 16-bit counter.
- FLUSH_CYC, 434000: idle-line cycles before a forced flush. 24-bit counter. Used only with the macro.

Ports:
- sys_clk, in, 1: system clock.
- sys_rst_n, in, 1: asynchronous reset, active-low.
- rx_done, in, 1: one-cycle pulse per received byte, the same strobe as the FIFO wrreq.
- fifo_empty, in, 1: FIFO empty flag.
- fifo_full, in, 1: FIFO full flag.
- fifo_usedw, in, AW: FIFO fill level.
- fifo_q, in, 8: FIFO read data. Normal (non-show-ahead) mode: valid the cycle after fifo_rdreq.
- fifo_rdreq, out, 1: one-cycle pop strobe.
- tx_en, out, 1: one-cycle start pulse to the transmitter.
- tx_data, out, 8: byte to transmit. Held stable from tx_en until the next RD.
- tx_busy, in, 1: high while the transmitter shifts a frame.
- sched_active, out, 1: high in every state except IDLE.
- tx_err, out, 1: sticky flag, set on busy timeout. Cleared only by reset.

## Operation
- Reset value of every output is 0. Counters reset to 0, state resets to IDLE, and the burst latch is cleared.
- States:
  - IDLE → RD when fifo_empty=0 and any of: fifo_usedw ≥ THRESH, fifo_full=1, or flush_req (macro only). Entering RD sets the burst latch.
  - RD: fifo_rdreq=1 for exactly one cycle → LATCH.
  - LATCH: tx_data ← fifo_q → SEND.
  - SEND: tx_en=1 for exactly one cycle → WAIT_HI.
  - WAIT_HI: on tx_busy=1 → WAIT_LO. If BUSY_TO cycles pass with no rise, set tx_err and → GAP. The byte is dropped, not retried.
  - WAIT_LO: on tx_busy=0 → GAP.
  - GAP: count GAP_CYC cycles; GAP_CYC=0 means exactly one cycle in GAP. On exit, → RD if the burst latch is set and fifo_empty=0. Otherwise → IDLE and clear the latch.
- A started burst drains to empty even if the level falls below THRESH.
- Bytes written during a burst are part of that burst.
- fifo_rdreq is never asserted while fifo_empty=1.
- The controller never issues a second pop before the previous frame's tx_busy falls, or before the busy timeout expires.
- rx_done in the same cycle as fifo_rdreq is legal. The FIFO handles simultaneous read and write. fifo_usedw is sampled only in IDLE and GAP.
- tx_busy already high in SEND (transmitter not idle) is still accepted as the rise in WAIT_HI.
- Reset asserted mid-frame: the FSM returns to IDLE immediately and tx_en drops. The transmitter and FIFO have their own resets.

## Timing
- Pop-to-start latency: RD at cycle n, tx_data valid at n+2, tx_en at n+2.
- IDLE trigger to RD: 1 cycle (registered decision).
- Minimum frame-to-frame spacing: tx_busy fall → next tx_en = 1 (GAP) + GAP_CYC' + 3 cycles, where GAP_CYC' = max(GAP_CYC−1, 0).
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- UART_TX_FLUSH_EN defined:
  - A 24-bit idle counter clears on rx_done or when fifo_empty=1, and otherwise increments and saturates.
  - flush_req is asserted when the counter equals FLUSH_CYC; it starts a burst from IDLE regardless of THRESH.
  - The counter clears when a burst starts.
- UART_TX_FLUSH_EN undefined: no counter and flush_req ≡ 0. Bytes below THRESH stay in the FIFO until more arrive.

## Structure
- Shared package: state encoding (3-bit localparams IDLE, RD, LATCH, SEND, WAIT_HI, WAIT_LO, GAP) and counter-width constants (16 for gap/timeout, 24 for flush).
- One sub-module: uart_tx_flush_timer, the idle counter plus compare, instantiated only under UART_TX_FLUSH_EN.
- The FSM, gap counter and timeout counter stay in the top.

## Test plan
- THRESH=4: write 3 bytes → no fifo_rdreq for 10k cycles (macro off). Write a 4th → 4 pops, and tx_data sequence 0x11,0x22,0x33,0x44 in write order.
- Burst with tx_busy model high 100 cycles after each tx_en → exactly one tx_en per busy fall. fifo_rdreq never high while fifo_empty=1.
- GAP_CYC=5: measure tx_busy fall → next tx_en = 8 cycles. GAP_CYC=0 → 4 cycles.
- tx_busy held 0 → tx_err set BUSY_TO cycles after tx_en, next byte still popped, tx_err stays 1.
- Macro on, FLUSH_CYC=1000, 2 bytes written then line idle → burst starts 1001 cycles after last rx_done, 2 bytes sent, return to IDLE.
- sys_rst_n pulsed low during WAIT_LO → all outputs 0 in the same cycle, state IDLE, and normal operation after release.
